// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding selects, load-use and scoreboard stalls,
// and redirect flushes for a DE/EX/MEM/WB pipeline with variable-latency units.
// The scoreboard tracks destinations of in-flight multi-cycle ops. Register 0
// is never tracked and never matches for forwarding or hazard detection.
module hazard_scoreboard_unit #(
    parameter int NUM_SRC         = 2,
    parameter int NUM_REGS        = 32,
    parameter int LOAD_STALL      = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   CLK,
    input  logic                                   RST,
    input  logic [5*NUM_SRC-1:0]                   de_adr,
    input  logic [NUM_SRC-1:0]                     de_used,
    input  logic [4:0]                             de_rd,
    input  logic                                   de_regWrite,
    input  logic                                   de_mc,
    input  logic [5*NUM_SRC-1:0]                   ex_adr,
    input  logic [NUM_SRC-1:0]                     ex_used,
    input  logic [4:0]                             ex_rd,
    input  logic                                   ex_is_load,
    input  logic [4:0]                             mem_rd,
    input  logic                                   mem_regWrite,
    input  logic [4:0]                             wb_rd,
    input  logic                                   wb_regWrite,
    input  logic [1:0]                             pc_source,
    input  logic                                   mc_issue,
    input  logic [4:0]                             mc_rd,
    input  logic                                   mc_done,
    input  logic [4:0]                             mc_done_rd,
    output logic [2*NUM_SRC-1:0]                   fsel,
    output logic                                   stall,
    output logic                                   bubble_ex,
    output logic                                   flush,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   pending_cnt,
    output logic                                   sb_full
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [2:0]    LU_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0]    FL_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);

    logic [NUM_REGS-1:0] sb_q, sb_d;
    logic [2:0]          lu_cnt_q, lu_cnt_d;
    logic [2:0]          fl_cnt_q, fl_cnt_d;
    logic [CW-1:0]       pend_q, pend_d;

    logic redirect;
    logic lu_det;
    logic sb_haz;
    logic hold;
    logic issue_ok;
    logic done_ok;

    // Scoreboard lookup; r0 and out-of-range addresses always read as free.
    function automatic logic sb_hit(input logic [NUM_REGS-1:0] sb, input logic [4:0] r);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (r == 5'(k)) hit = sb[k];
        end
        return hit;
    endfunction

    // Forward select per EX operand: MEM result first, then WB, else regfile.
    always_comb begin
        logic [4:0] src;
        fsel = '0;
        src  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src = ex_adr[5*i +: 5];
            if (ex_used[i] && (src != 5'd0)) begin
                if (mem_regWrite && (mem_rd == src)) begin
                    fsel[2*i +: 2] = 2'b01;
                end else if (wb_regWrite && (wb_rd == src)) begin
                    fsel[2*i +: 2] = 2'b10;
                end
            end
        end
    end

    // Hazard detection: load-use against EX, RAW/WAW/capacity against the scoreboard.
    always_comb begin
        lu_det = 1'b0;
        sb_haz = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ex_is_load && (ex_rd != 5'd0) && de_used[i] && (de_adr[5*i +: 5] == ex_rd)) begin
                lu_det = 1'b1;
            end
            if (de_used[i] && sb_hit(sb_q, de_adr[5*i +: 5])) begin
                sb_haz = 1'b1;
            end
        end
        if (de_regWrite && sb_hit(sb_q, de_rd)) sb_haz = 1'b1;
        if (de_mc && sb_full) sb_haz = 1'b1;
    end

    // Pipeline control outputs; a flush masks every stall source.
    always_comb begin
        redirect    = (pc_source != 2'b00);
        flush       = redirect || (fl_cnt_q != 3'd0);
        hold        = lu_det || (lu_cnt_q != 3'd0) || sb_haz;
        stall       = hold && !flush;
        bubble_ex   = hold && !flush;
        pending_cnt = pend_q;
        sb_full     = (pend_q == MAX_CNT);
    end

    // Next state for the stall/flush countdowns.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (flush) begin
            lu_cnt_d = 3'd0;
        end else if (lu_det) begin
            lu_cnt_d = LU_RELOAD;
        end else if (lu_cnt_q != 3'd0) begin
            lu_cnt_d = lu_cnt_q - 3'd1;
        end
        if (redirect) begin
            fl_cnt_d = FL_RELOAD;
        end else if (fl_cnt_q != 3'd0) begin
            fl_cnt_d = fl_cnt_q - 3'd1;
        end
    end

    // Next state for the scoreboard; a same-register set is applied after the
    // clear so the newer issue wins over the completion of the older op.
    always_comb begin
        issue_ok = mc_issue && !sb_full;
        done_ok  = mc_done && (pend_q != '0);
        sb_d     = sb_q;
        for (int unsigned k = 1; k < NUM_REGS; k++) begin
            if (done_ok && (mc_done_rd == 5'(k))) sb_d[k] = 1'b0;
            if (issue_ok && (mc_rd == 5'(k)))     sb_d[k] = 1'b1;
        end
        sb_d[0] = 1'b0;
        case ({issue_ok, done_ok})
            2'b10:   pend_d = pend_q + CW'(1);
            2'b01:   pend_d = pend_q - CW'(1);
            default: pend_d = pend_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb_q     <= '0;
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            pend_q   <= '0;
        end else begin
            sb_q     <= sb_d;
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            pend_q   <= pend_d;
        end
    end

    a_no_issue_when_full: assert property (@(posedge CLK) disable iff (RST)
        !(mc_issue && sb_full));
    a_no_done_when_empty: assert property (@(posedge CLK) disable iff (RST)
        !(mc_done && (pend_q == '0)));

endmodule
